sub16_serial: RTL



---
 rtl/sub16_serial_pkg.sv | 7 +
 rtl/sub16_serial_sub_slice.sv | 14 +
 rtl/sub16_serial.sv | 73 +++++++
 3 files changed

// File: rtl/sub16_serial_pkg.sv
// sub16_serial_pkg: shared width, slice size, slice count and FSM encoding for the serial subtractor
package sub16_serial_pkg;
  localparam int SIZE = 16;
  localparam int SLICE_W = 4;
  localparam int N_SLICES = SIZE / SLICE_W;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/sub16_serial_sub_slice.sv
// sub_slice: combinational SLICE-bit subtractor built as a + ~b + ~borrow_in
module sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             borrow_in,
  output logic [SLICE-1:0] d_i,
  output logic             borrow_out
);
  logic carry;
  assign {carry, d_i} = {1'b0, a_i} + {1'b0, ~b_i} + {{SLICE{1'b0}}, ~borrow_in};
  assign borrow_out = ~carry;
endmodule

// File: rtl/sub16_serial.sv
// sub16_serial: multi-cycle a - b - bin, one SLICE-bit slice per clock, LS slice first
module sub16_serial
  import sub16_serial_pkg::*;
#(
  parameter int WIDTH = SIZE,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int N = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, shadow, sh_nxt;
  logic             br, bo;
  logic [IW-1:0]    idx;
  logic [SLICE-1:0] a_i, b_i, d_i;
  assign a_i = a_q[idx*SLICE +: SLICE];
  assign b_i = b_q[idx*SLICE +: SLICE];
  sub_slice #(.SLICE(SLICE)) u_slice (
    .a_i(a_i), .b_i(b_i), .borrow_in(br), .d_i(d_i), .borrow_out(bo)
  );
  // diff is loaded from the merged shadow so it never shows a half-updated word
  always_comb begin
    sh_nxt = shadow;
    sh_nxt[idx*SLICE +: SLICE] = d_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      shadow <= '0;
      br     <= 1'b0;
      idx    <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_q   <= a;
          b_q   <= b;
          br    <= bin;
          idx   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
      end else begin
        shadow <= sh_nxt;
        br     <= bo;
        idx    <= idx + 1'b1;
        if (idx == IW'(N - 1)) begin
          diff  <= sh_nxt;
          bout  <= bo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule
